// File: rtl/irq_ctrl_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_8_pkg
// Description : Shared constants, FSM encoding and helpers for irq_ctrl_8
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_8_pkg;

   localparam int NUM_CH = 8;   // interrupt channels
   localparam int VEC_W  = 3;   // encoded vector width

   // Handshake FSM encoding
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // Expand a channel index into a one-hot channel vector
   function automatic logic [NUM_CH-1:0] vec_onehot(input logic [VEC_W-1:0] vec);
      vec_onehot      = '0;
      vec_onehot[vec] = 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_8_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_8_if
// Description : Request lines, mask access and vector handshake bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_8_if;
   import irq_ctrl_8_pkg::*;

   logic [NUM_CH-1:0] irq;
   logic              mask_we;
   logic [NUM_CH-1:0] mask_in;
   logic              int_ack;
   logic              int_req;
   logic [VEC_W-1:0]  int_vec;
   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] mask;

   // Request sources, mask writer and vector consumer
   modport master (
      output irq, mask_we, mask_in, int_ack,
      input  int_req, int_vec, pending, mask
   );

   // Interrupt controller
   modport slave (
      input  irq, mask_we, mask_in, int_ack,
      output int_req, int_vec, pending, mask
   );

endinterface
`default_nettype wire

// File: rtl/p_enc_8x3.sv
`default_nettype none
// ============================================================================
// Module      : p_enc_8x3
// Description : 8-to-3 priority encoder, bit 7 highest priority
// Revision    : 1.0 - initial release
// ============================================================================
module p_enc_8x3 (
   input  logic [7:0] d,
   output logic [2:0] q,
   output logic       v
);

   // Ascending scan so the highest set bit is the last one to win
   always_comb begin
      q = 3'd0;
      v = |d;
      for (int i = 0; i < 8; i++) begin
         if (d[i]) q = 3'(i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl_8.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_8
// Description : Eight-channel interrupt front-end: sync, edge detect,
//               pending/mask state and registered req/ack vector handshake
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl_8
   import irq_ctrl_8_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   irq_ctrl_8_if.slave   bus
);

   logic [NUM_CH-1:0] r_s1;
   logic [NUM_CH-1:0] r_s2;
   logic [NUM_CH-1:0] r_s3;
   logic [NUM_CH-1:0] r_pending;
   logic [NUM_CH-1:0] r_mask;
   state_t            r_state;
   logic              r_int_req;
   logic [VEC_W-1:0]  r_int_vec;

   logic [NUM_CH-1:0] w_edge;
   logic [NUM_CH-1:0] w_clr;
   logic [NUM_CH-1:0] w_enc_d;
   logic [VEC_W-1:0]  w_enc_q;
   logic              w_enc_v;

   // Rising edge on the synchronised line; s3 holds the previous s2 value
   assign w_edge = r_s2 & ~r_s3;

   // Only an acknowledge of the committed vector clears its pending bit
   assign w_clr = (r_state == REQ && bus.int_ack) ? vec_onehot(r_int_vec) : '0;

   // Masked channels stay pending but are hidden from the encoder
   assign w_enc_d = r_pending & ~r_mask;

   p_enc_8x3 u_enc (
      .d (w_enc_d),
      .q (w_enc_q),
      .v (w_enc_v)
   );

   // Two-flop synchroniser plus history flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= bus.irq;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   // Pending register: a new edge outranks a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= (r_pending & ~w_clr) | w_edge;
   end

   // Mask register, written by strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)           r_mask <= '0;
      else if (bus.mask_we) r_mask <= bus.mask_in;
   end

   // Handshake FSM: commit a vector in IDLE, hold it in REQ until acknowledged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_int_req <= 1'b0;
         r_int_vec <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_enc_v) begin
                  r_int_vec <= w_enc_q;
                  r_int_req <= 1'b1;
                  r_state   <= REQ;
               end
            end
            REQ: begin
               if (bus.int_ack) begin
                  r_int_req <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_int_req <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign bus.int_req = r_int_req;
   assign bus.int_vec = r_int_vec;
   assign bus.pending = r_pending;
   assign bus.mask    = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl_8
// Description : Scoreboard bench for irq_ctrl_8 with a priority-order model
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_irq_ctrl_8;
   import irq_ctrl_8_pkg::*;

   typedef struct packed {
      logic [2:0] vec;
      logic [7:0] pend;
      logic [7:0] msk;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   irq_ctrl_8_if bus();

   irq_ctrl_8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t       sb[$];
   int         checks   = 0;
   int         errors   = 0;
   logic [7:0] m_pend   = 8'h00;   // model: channels with an unserved event
   logic [7:0] m_mask   = 8'h00;   // model: mask register
   logic       mon_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serve order: exposed channels from highest index down, each clearing as served
   task automatic push_exposed(output int n);
      logic [7:0] e;
      exp_t       x;
      int         b;
      n = 0;
      e = m_pend & ~m_mask;
      while (e != 8'h00) begin
         b = -1;
         for (int i = 7; i >= 0; i--) if (e[i] && b < 0) b = i;
         x.vec  = 3'(b);
         x.pend = m_pend;
         x.msk  = m_mask;
         sb.push_back(x);
         m_pend[b] = 1'b0;
         e[b]      = 1'b0;
         n++;
      end
   endtask

   task automatic wait_req();
      int t = 0;
      while (!bus.int_req && t < 20) begin
         tick();
         t++;
      end
      if (!bus.int_req) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: int_req=0 after %0d cycles, expected 1", t);
      end
   endtask

   task automatic handshake();
      wait_req();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
   endtask

   task automatic set_mask(input logic [7:0] m);
      bus.mask_we = 1'b1;
      bus.mask_in = m;
      tick();
      bus.mask_we = 1'b0;
      m_mask      = m;
      check("mask_rd", bus.mask, m);
   endtask

   // Write a mask, drain what it exposes, then raise a burst and drain again
   task automatic run_round(input logic [7:0] r, input logic [7:0] m);
      int n;
      set_mask(m);
      push_exposed(n);
      repeat (n) handshake();
      m_pend = m_pend | r;
      push_exposed(n);
      bus.irq = r;
      tick();
      tick();
      bus.irq = 8'h00;
      repeat (n) handshake();
      repeat (4) tick();
      check("idle_req", bus.int_req, 0);
      check("idle_pend", bus.pending, m_pend);
   endtask

   // Monitor: every new request must match the next scoreboard entry
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.int_req && !mon_prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: int_req with int_vec=%0d, no request expected", bus.int_vec);
            end else begin
               e = sb.pop_front();
               check("sb_vec", bus.int_vec, e.vec);
               check("sb_pend", bus.pending, e.pend);
               check("sb_mask", bus.mask, e.msk);
            end
         end
         mon_prev = bus.int_req;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      exp_t x;
      bus.irq     = 8'h00;
      bus.mask_we = 1'b0;
      bus.mask_in = 8'h00;
      bus.int_ack = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_req", bus.int_req, 0);
      check("rst_vec", bus.int_vec, 0);
      check("rst_pend", bus.pending, 8'h00);
      check("rst_mask", bus.mask, 8'h00);
      rst_n = 1'b1;
      tick();
      tick();

      // Single event on channel 3, latency from the first capturing edge
      m_pend = 8'h08;
      push_exposed(n);
      bus.irq = 8'h08;
      tick();
      tick();
      tick();
      check("single_pend", bus.pending, 8'h08);
      check("single_req_early", bus.int_req, 0);
      bus.irq = 8'h00;
      tick();
      check("single_req", bus.int_req, 1);
      check("single_vec", bus.int_vec, 3);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("single_ack_req", bus.int_req, 0);
      check("single_ack_pend", bus.pending, 8'h00);
      repeat (3) tick();

      // Priority: channels 6, 5, 1 together
      run_round(8'h62, 8'h00);

      // Masking: channel 7 masked while 2 is served, then unmasked
      run_round(8'h84, 8'h80);
      check("mask_hold_pend", bus.pending, 8'h80);
      run_round(8'h00, 8'h00);

      // Commit hold: vector 1 stays through a channel 4 edge and a mask write
      m_pend = m_pend | 8'h02;
      push_exposed(n);
      bus.irq = 8'h02;
      tick();
      tick();
      bus.irq = 8'h00;
      wait_req();
      check("hold_vec0", bus.int_vec, 1);
      bus.irq = 8'h10;
      tick();
      tick();
      bus.irq = 8'h00;
      repeat (3) tick();
      set_mask(8'h02);
      tick();
      check("hold_req", bus.int_req, 1);
      check("hold_vec", bus.int_vec, 1);
      check("hold_pend", bus.pending, 8'h12);
      m_pend = m_pend | 8'h10;
      push_exposed(n);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      handshake();
      repeat (3) tick();
      set_mask(8'h00);
      repeat (3) tick();

      // Set/clear collision on channel 3
      m_pend = m_pend | 8'h08;
      push_exposed(n);
      bus.irq = 8'h08;
      tick();
      tick();
      bus.irq = 8'h00;
      wait_req();
      check("col_vec", bus.int_vec, 3);
      bus.irq = 8'h08;
      tick();
      tick();
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("col_req_drop", bus.int_req, 0);
      check("col_pend_kept", bus.pending, 8'h08);
      m_pend = m_pend | 8'h08;
      push_exposed(n);
      bus.irq = 8'h00;
      tick();
      check("col_rereq", bus.int_req, 1);
      check("col_revec", bus.int_vec, 3);
      bus.int_ack = 1'b1;
      tick();
      bus.int_ack = 1'b0;
      check("col_pend_clr", bus.pending, 8'h00);
      repeat (3) tick();

      // Randomised bursts under random masks, then a full drain
      for (int k = 0; k < 12; k++) begin
         run_round(8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255) & $urandom_range(0, 255)));
      end
      run_round(8'h00, 8'h00);

      // Asynchronous reset in the middle of a handshake
      set_mask(8'h01);
      m_pend = 8'h24;
      x.vec  = 3'd5;
      x.pend = 8'h24;
      x.msk  = 8'h01;
      sb.push_back(x);
      bus.irq = 8'h24;
      tick();
      tick();
      bus.irq = 8'h00;
      wait_req();
      check("arst_pre_vec", bus.int_vec, 5);
      check("arst_pre_pend", bus.pending, 8'h24);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req", bus.int_req, 0);
      check("arst_vec", bus.int_vec, 0);
      check("arst_pend", bus.pending, 8'h00);
      check("arst_mask", bus.mask, 8'h00);
      m_pend = 8'h00;
      m_mask = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;
      repeat (8) tick();
      check("arst_post_req", bus.int_req, 0);
      check("arst_post_pend", bus.pending, 8'h00);

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/irq_ctrl_8.md
# irq_ctrl_8

Eight-channel interrupt request front-end that sits directly upstream of the 8-to-3 priority encoder. It synchronises raw request lines, detects rising edges, and holds pending and mask state. It drives the masked pending vector into the encoder and turns the encoder result into a registered request/acknowledge handshake toward the consumer. Channel 7 has the highest priority and channel 0 the lowest, matching the encoder ordering.

## Interface
- No parameters; channel count fixed at 8, vector width fixed at 3.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- irq  in  8  raw request lines, asynchronous to clk, level; an event is a 0→1 transition
- mask_we  in  1  write strobe for mask register
- mask_in  in  8  new mask value; 1 = channel masked
- int_ack  in  1  consumer acknowledge of the presented vector
- int_req  out  1  registered request; a vector is valid and stable
- int_vec  out  3  registered index of the serviced channel
- pending  out  8  pending register, for status readback
- mask  out  8  mask register, for status readback

## Operation
- Synchroniser: 2-flop chain per bit (s1, s2) plus history flop s3.
- edge[i] = s2[i] & ~s3[i].
- Pending: pending[i] sets on edge[i] and clears only on acknowledge of vector i. If set and clear hit the same bit in the same cycle, set wins, so the new event is kept.
- Mask: written with mask_in when mask_we=1. Masking never clears pending; unmasking re-exposes a bit that is still pending.
- Encoder input D = pending & ~mask. Encoder outputs are Q[2:0] and v.
- FSM states:
  - IDLE: int_req=0. If v=1, latch int_vec←Q and go to REQ; otherwise stay.
  - REQ: int_req=1, int_vec held. On int_ack=1, clear pending[int_vec] and go to IDLE.
- A vector committed in REQ is held until acknowledged, even if the channel becomes masked or a higher-priority edge arrives.
- int_ack is ignored in IDLE.
- Reset (async, any time, including mid-handshake): s1/s2/s3, pending and mask go to 0; FSM goes to IDLE; int_req=0; int_vec=0. In-flight events are lost.

## Timing
- Reset values: int_req=0, int_vec=3'd0, pending=8'h00, mask=8'h00.
- irq[i] rises before clock edge k, with all other state idle:
  - s2 high after edge k+1.
  - pending[i]=1 after edge k+2.
  - int_req=1 with int_vec=i after edge k+3.
- Acknowledge: int_ack=1 sampled at edge m while in REQ. After edge m, int_req=0 and pending bit cleared. The earliest next int_req is after edge m+1, so int_req is low for at least one cycle between vectors.
- Acknowledge in the same cycle as int_req first rises is legal and completes at that edge.
- Mask write takes effect after its edge. An IDLE decision in the same cycle uses the old mask.
- Channel held high: only one event. A re-trigger needs irq low for at least 2 clk cycles, then high again.

## Structure
- Shared package: channel count constant (8), vector width constant (3), FSM state encoding IDLE=1'b0 / REQ=1'b1.
- One sub-module: instantiate the existing p_enc_8x3 combinationally, with D=pending&~mask, Q→vector capture and v→FSM.
- Synchroniser and edge detect stay inline. Expected size is about 150 lines.

## Test plan
- Reset: assert rst_n=0 mid-REQ with pending=8'h24. Outputs go to 0 asynchronously, before the next clk edge; after release, no int_req without a new edge.
- Single event: irq=8'h08 pulse held 3 cycles. pending=8'h08 after 3 edges; int_req=1, int_vec=3 after 4 edges; int_ack for 1 cycle gives int_req=0, pending=8'h00.
- Priority: irq bits 1, 5 and 6 rise together. Vectors are served in order 6, 5, 1, each with int_ack. pending reads 8'h22, then 8'h02, then 8'h00.
- Masking: mask=8'h80, then irq bit 7 and bit 2 rise. Vector 2 is served while pending[7] stays 1. Writing mask=8'h00 then yields int_vec=7.
- Commit hold: in REQ with int_vec=1, a bit-4 edge and a mask write of 8'h02 do not change int_vec (stays 1) until int_ack. The next vector is 4.
- Set/clear collision: a new bit-3 edge reaches pending in the same cycle as int_ack for vector 3. pending[3] stays 1, and int_req re-asserts with int_vec=3 after one idle cycle.
